// File: rtl/jt12_comb_pkg.sv
// Shared types and limits for the multichannel comb filter: FSM state encoding,
// parameter bounds and the minimum-one-bit width helper used for channel and stage indices.
package jt12_comb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int M_MAX  = 4;
    localparam int N_MAX  = 5;
    localparam int CH_MAX = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int chw_calc(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jt12_comb_mch_if.sv
// Sample-in / result-out bundle of the comb filter; the filter is the slave,
// the upstream source and downstream sink together form the master side.
interface jt12_comb_mch_if #(
    parameter int W   = 16,
    parameter int CHW = 1
);
    logic signed [W-1:0]   din;
    logic        [CHW-1:0] din_ch;
    logic                  din_valid;
    logic                  din_ready;
    logic signed [W-1:0]   dout;
    logic        [CHW-1:0] dout_ch;
    logic                  dout_valid;

    modport slave  (input  din, din_ch, din_valid,
                    output din_ready, dout, dout_ch, dout_valid);
    modport master (output din, din_ch, din_valid,
                    input  din_ready, dout, dout_ch, dout_valid);
endinterface

// File: rtl/jt12_comb_dly.sv
// Per-channel, per-stage comb history (CH x N x M words); one (ch, stage) row is
// read at its oldest tap and shifted in the same cycle.
module jt12_comb_dly
    import jt12_comb_pkg::*;
#(
    parameter int W  = 16,
    parameter int M  = 1,
    parameter int N  = 1,
    parameter int CH = 2,
    localparam int CHW = chw_calc(CH),
    localparam int SW  = chw_calc(N)
) (
    input  logic                 rst,
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [CHW-1:0]       i_ch,
    input  logic [SW-1:0]        i_stage,
    input  logic signed [W-1:0]  i_wdata,
    output logic signed [W-1:0]  o_tap
);

    logic signed [W-1:0] r_mem [CH][N][M];

    // NOTE: this storage is reset on purpose -- a reset must leave every channel with zero history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CH; c++)
                for (int s = 0; s < N; s++)
                    for (int m = 0; m < M; m++)
                        r_mem[c][s][m] <= '0;
        end else if (i_we) begin
            r_mem[i_ch][i_stage][0] <= i_wdata;
            for (int m = 1; m < M; m++)
                r_mem[i_ch][i_stage][m] <= r_mem[i_ch][i_stage][m-1];
        end
    end

    assign o_tap = r_mem[i_ch][i_stage][M-1];

endmodule

// File: rtl/jt12_comb_mch.sv
// Time-multiplexed N-stage CIC comb (delay M) for CH channels, one stage per cen cycle.
// Optional bypass port byp is built when JT12_COMB_MCH_BYPASS_EN is defined.
module jt12_comb_mch
    import jt12_comb_pkg::*;
#(
    parameter int W  = 16,
    parameter int M  = 1,
    parameter int N  = 1,
    parameter int CH = 2
) (
    input  logic rst,
    input  logic clk,
    input  logic cen,
`ifdef JT12_COMB_MCH_BYPASS_EN
    input  logic byp,
`endif
    jt12_comb_mch_if.slave bus
);

    localparam int CHW = chw_calc(CH);
    localparam int SW  = chw_calc(N);
    localparam logic [SW-1:0] LAST   = SW'(N - 1);
    localparam logic [CHW:0]  CH_LIM = (CHW + 1)'(CH);

    if (M < 1 || M > M_MAX || N < 1 || N > N_MAX || CH < 1 || CH > CH_MAX) begin : g_bad_param
        $error("jt12_comb_mch: parameter out of range");
    end

    state_t              r_state;
    logic signed [W-1:0] r_acc;
    logic signed [W-1:0] r_dout;
    logic [SW-1:0]       r_stage;
    logic [CHW-1:0]      r_ch;
    logic [CHW-1:0]      r_dout_ch;
    logic                r_ready;
    logic                r_dout_valid;
    logic signed [W-1:0] w_tap;
    logic signed [W-1:0] w_diff;
    logic signed [W-1:0] w_result;
    logic                w_accept;
    logic                w_we;

    // Out-of-range channel indices are never accepted, so the history stays untouched.
    assign w_accept = (r_state == ST_IDLE) && bus.din_valid && ({1'b0, bus.din_ch} < CH_LIM);
    assign w_we     = cen && (r_state == ST_CALC);
    assign w_diff   = r_acc - w_tap;

`ifdef JT12_COMB_MCH_BYPASS_EN
    logic                r_byp;
    logic signed [W-1:0] r_raw;
    assign w_result = r_byp ? r_raw : w_diff;
`else
    assign w_result = w_diff;
`endif

    jt12_comb_dly #(
        .W  (W),
        .M  (M),
        .N  (N),
        .CH (CH)
    ) u_dly (
        .rst     (rst),
        .clk     (clk),
        .i_we    (w_we),
        .i_ch    (r_ch),
        .i_stage (r_stage),
        .i_wdata (r_acc),
        .o_tap   (w_tap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_acc        <= '0;
            r_stage      <= '0;
            r_ch         <= '0;
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_valid <= 1'b0;
            r_ready      <= 1'b1;
`ifdef JT12_COMB_MCH_BYPASS_EN
            r_byp        <= 1'b0;
            r_raw        <= '0;
`endif
        end else if (cen) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_acc   <= bus.din;
                        r_ch    <= bus.din_ch;
                        r_stage <= '0;
                        r_ready <= 1'b0;
                        r_state <= ST_CALC;
`ifdef JT12_COMB_MCH_BYPASS_EN
                        r_byp   <= byp;
                        r_raw   <= bus.din;
`endif
                    end
                end
                ST_CALC: begin
                    // The pre-subtraction acc enters the history inside u_dly on this same edge.
                    r_acc   <= w_diff;
                    r_stage <= r_stage + 1'b1;
                    if (r_stage == LAST) begin
                        r_dout       <= w_result;
                        r_dout_ch    <= r_ch;
                        r_dout_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_dout_valid <= 1'b0;
                    r_ready      <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.din_ready  = r_ready;
    assign bus.dout       = r_dout;
    assign bus.dout_ch    = r_dout_ch;
    assign bus.dout_valid = r_dout_valid;

endmodule

// File: tb/tb_jt12_comb_mch.sv
// Bench for jt12_comb_mch: four configurations checked against a binomial (1 - z^-M)^N
// reference over each channel's accepted-sample history; JT12_COMB_MCH_BYPASS_EN adds the bypass case.
module tb_jt12_comb_mch;

    localparam int NP    [4] = '{1, 2, 1, 3};
    localparam int MP    [4] = '{1, 2, 1, 2};
    localparam int CP    [4] = '{1, 1, 2, 3};
    localparam int CHMAX [4] = '{1, 1, 1, 3};

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic phase = 1'b0;

    logic signed [15:0] din_v  [4];
    logic [1:0]         dch_v  [4];
    logic               val_v  [4];
    logic signed [15:0] dout_v [4];
    logic [1:0]         doch_v [4];
    logic               dval_v [4];
    logic               rdy_v  [4];
`ifdef JT12_COMB_MCH_BYPASS_EN
    logic               byp_v  [4];
`endif

    logic signed [15:0] hist [4][4][16];
    int vectors     = 0;
    int miscompares = 0;
    bit keep_next   = 1'b0;
    logic signed [15:0] nx;
    logic [1:0]         nch;

    jt12_comb_mch_if #(.W(16), .CHW(1)) bus0 ();
    jt12_comb_mch_if #(.W(16), .CHW(1)) bus1 ();
    jt12_comb_mch_if #(.W(16), .CHW(1)) bus2 ();
    jt12_comb_mch_if #(.W(16), .CHW(2)) bus3 ();

    assign bus0.din = din_v[0];  assign bus0.din_ch = dch_v[0][0];  assign bus0.din_valid = val_v[0];
    assign bus1.din = din_v[1];  assign bus1.din_ch = dch_v[1][0];  assign bus1.din_valid = val_v[1];
    assign bus2.din = din_v[2];  assign bus2.din_ch = dch_v[2][0];  assign bus2.din_valid = val_v[2];
    assign bus3.din = din_v[3];  assign bus3.din_ch = dch_v[3];     assign bus3.din_valid = val_v[3];

    assign dout_v[0] = bus0.dout;  assign doch_v[0] = {1'b0, bus0.dout_ch};
    assign dout_v[1] = bus1.dout;  assign doch_v[1] = {1'b0, bus1.dout_ch};
    assign dout_v[2] = bus2.dout;  assign doch_v[2] = {1'b0, bus2.dout_ch};
    assign dout_v[3] = bus3.dout;  assign doch_v[3] = bus3.dout_ch;
    assign dval_v[0] = bus0.dout_valid;  assign rdy_v[0] = bus0.din_ready;
    assign dval_v[1] = bus1.dout_valid;  assign rdy_v[1] = bus1.din_ready;
    assign dval_v[2] = bus2.dout_valid;  assign rdy_v[2] = bus2.din_ready;
    assign dval_v[3] = bus3.dout_valid;  assign rdy_v[3] = bus3.din_ready;

    jt12_comb_mch #(.W(16), .M(1), .N(1), .CH(1)) dut0 (
        .rst(rst), .clk(clk), .cen(1'b1),
`ifdef JT12_COMB_MCH_BYPASS_EN
        .byp(byp_v[0]),
`endif
        .bus(bus0));
    jt12_comb_mch #(.W(16), .M(2), .N(2), .CH(1)) dut1 (
        .rst(rst), .clk(clk), .cen(1'b1),
`ifdef JT12_COMB_MCH_BYPASS_EN
        .byp(byp_v[1]),
`endif
        .bus(bus1));
    jt12_comb_mch #(.W(16), .M(1), .N(1), .CH(2)) dut2 (
        .rst(rst), .clk(clk), .cen(1'b1),
`ifdef JT12_COMB_MCH_BYPASS_EN
        .byp(byp_v[2]),
`endif
        .bus(bus2));
    jt12_comb_mch #(.W(16), .M(2), .N(3), .CH(3)) dut3 (
        .rst(rst), .clk(clk), .cen(phase),
`ifdef JT12_COMB_MCH_BYPASS_EN
        .byp(byp_v[3]),
`endif
        .bus(bus3));

    initial forever #5 clk = ~clk;
    // Instance 3 sees cen on every second rising edge.
    initial forever begin
        @(posedge clk);
        #2 phase = ~phase;
    end

    function automatic bit cen_eff(input int k);
        return (k != 3) || phase;
    endfunction

    // y[n] = sum_j (-1)^j C(N,j) x[n - j*M], wrapped to 16 bits.
    function automatic logic signed [15:0] model(input int k, input int c);
        int acc = 0;
        int bn  = 1;
        for (int j = 0; j <= NP[k]; j++) begin
            acc += ((j % 2) ? -bn : bn) * int'(hist[k][c][j * MP[k]]);
            bn = bn * (NP[k] - j) / (j + 1);
        end
        return 16'(acc);
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 4; c++)
                for (int i = 0; i < 16; i++)
                    hist[k][c][i] = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input int k, input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL u%0d_%s: observed %0d, expected %0d", k, tag, obs, exp);
        end
    endtask

    task automatic wait_cen(input int k);
        int g = 0;
        while (!cen_eff(k) && g < 8) begin
            step();
            g++;
        end
    endtask

    task automatic send(input int k, input int x, input int ch, input bit use_e,
                        input int e_in, input bit b);
        int g = 0;
        bit taken = 1'b0;
        logic signed [15:0] e;
        din_v[k] = 16'(x);
        dch_v[k] = 2'(ch);
        val_v[k] = 1'b1;
`ifdef JT12_COMB_MCH_BYPASS_EN
        byp_v[k] = b;
`endif
        while (!taken && g < 64) begin
            taken = rdy_v[k] && cen_eff(k);
            step();
            g++;
        end
        if (!taken) begin
            chk(k, "accept_timeout", 0, 1);
            val_v[k] = 1'b0;
            return;
        end
        for (int i = 15; i > 0; i--) hist[k][ch][i] = hist[k][ch][i-1];
        hist[k][ch][0] = 16'(x);
        e = b ? 16'(x) : model(k, ch);
        if (use_e) e = 16'(e_in);
        if (keep_next) begin
            din_v[k]  = nx;
            dch_v[k]  = nch;
            keep_next = 1'b0;
        end else begin
            val_v[k] = 1'b0;
        end
        for (int s = 0; s < NP[k]; s++) begin
            wait_cen(k);
            chk(k, "busy_ready", rdy_v[k], 0);
            chk(k, "busy_valid", dval_v[k], 0);
            step();
        end
        chk(k, "dout_valid", dval_v[k], 1);
        chk(k, "dout", dout_v[k], e);
        chk(k, "dout_ch", doch_v[k], ch);
        chk(k, "done_ready", rdy_v[k], 0);
        g = 0;
        while (!cen_eff(k) && g < 8) begin
            chk(k, "hold_valid", dval_v[k], 1);
            step();
            g++;
        end
        step();
        chk(k, "idle_valid", dval_v[k], 0);
        chk(k, "idle_ready", rdy_v[k], 1);
        chk(k, "dout_held", dout_v[k], e);
    endtask

    task automatic drop(input int k, input int ch);
        din_v[k] = 16'sh7fff;
        dch_v[k] = 2'(ch);
        val_v[k] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wait_cen(k);
            chk(k, "drop_ready", rdy_v[k], 1);
            chk(k, "drop_valid", dval_v[k], 0);
            step();
        end
        chk(k, "drop_ready_end", rdy_v[k], 1);
        val_v[k] = 1'b0;
    endtask

    initial begin
        int k;
        int ch;
        for (int i = 0; i < 4; i++) begin
            din_v[i] = '0;
            dch_v[i] = '0;
            val_v[i] = 1'b0;
`ifdef JT12_COMB_MCH_BYPASS_EN
            byp_v[i] = 1'b0;
`endif
        end
        clear_model();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk(i, "rst_valid", dval_v[i], 0);
            chk(i, "rst_ready", rdy_v[i], 1);
            chk(i, "rst_dout", dout_v[i], 0);
            chk(i, "rst_dout_ch", doch_v[i], 0);
        end
        rst = 1'b0;
        step();

        // First difference with wrap-around.
        send(0, 100, 0, 1, 100, 0);
        send(0, 250, 0, 1, 150, 0);
        send(0, 250, 0, 1, 0, 0);
        send(0, -32768, 0, 1, 32518, 0);

        // Impulse through two stages of delay 2.
        send(1, 1000, 0, 1, 1000, 0);
        send(1, 0, 0, 1, 0, 0);
        send(1, 0, 0, 1, -2000, 0);
        send(1, 0, 0, 1, 0, 0);
        send(1, 0, 0, 1, 1000, 0);
        send(1, 0, 0, 1, 0, 0);
        send(1, 0, 0, 1, 0, 0);

        // Two interleaved channels must not share history.
        send(2, 5, 0, 1, 5, 0);
        send(2, 0, 1, 1, 0, 0);
        send(2, 5, 0, 1, 0, 0);
        send(2, 10, 1, 1, 10, 0);
        send(2, 5, 0, 1, 0, 0);
        send(2, 20, 1, 1, 10, 0);

        // Slow cen, held valid across CALC/DONE, out-of-range channel dropped.
        keep_next = 1'b1;
        nx  = 16'sd200;
        nch = 2'd1;
        send(3, 100, 0, 1, 100, 0);
        send(3, 200, 1, 1, 200, 0);
        drop(3, 3);
        send(3, 30, 0, 1, 30, 0);
        send(3, 40, 0, 1, -260, 0);

        // Asynchronous reset in the middle of CALC wipes state and history.
        send(1, 500, 0, 0, 0, 0);
        send(1, 300, 0, 0, 0, 0);
        din_v[1] = 16'sd900;
        dch_v[1] = 2'd0;
        val_v[1] = 1'b1;
        step();
        val_v[1] = 1'b0;
        chk(1, "calc_ready", rdy_v[1], 0);
        step();
        #1 rst = 1'b1;
        #1;
        chk(1, "async_valid", dval_v[1], 0);
        chk(1, "async_ready", rdy_v[1], 1);
        chk(0, "async_dout", dout_v[0], 0);
        rst = 1'b0;
        clear_model();
        @(negedge clk);
        send(1, 7, 0, 1, 7, 0);

        for (int n = 0; n < 40; n++) begin
            k  = int'($urandom_range(3, 0));
            ch = int'($urandom_range(CHMAX[k], 0));
            if (ch >= CP[k]) drop(k, ch);
            else send(k, int'($urandom_range(65535, 0)), ch, 0, 0, 0);
        end

`ifdef JT12_COMB_MCH_BYPASS_EN
        send(0, 100, 0, 1, 100, 1);
        send(0, 250, 0, 1, 150, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jt12_comb_mch.md
JT12_COMB_MCH -- requirements
Module: jt12_comb_mch

Interface
REQ-001 Parameter W, default 16, signed sample width in bits.
REQ-002 Parameter M, default 1, differential delay per stage, legal 1..4.
REQ-003 Parameter N, default 1, number of cascaded comb stages, legal 1..5.
REQ-004 Parameter CH, default 2, number of time-multiplexed channels, legal 1..8; CHW = max(1, clog2(CH)).
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clk  input  1  single clock; all flops on rising edge.
REQ-007 cen  input  1  clock enable; state advances only on clk edges with cen=1.
REQ-008 din  input  W  signed input sample.
REQ-009 din_ch  input  CHW  channel index of din.
REQ-010 din_valid  input  1  din/din_ch valid.
REQ-011 din_ready  output  1  block accepts a sample; 1 exactly in state IDLE.
REQ-012 dout  output  W  signed filtered sample, held until next result.
REQ-013 dout_ch  output  CHW  channel of dout.
REQ-014 dout_valid  output  1  dout/dout_ch valid; 1 exactly in state DONE.

Function
REQ-015 States IDLE, CALC, DONE; every transition happens only on an edge with cen=1.
REQ-016 IDLE: din_valid=1 with din_ch<CH latches din into acc and din_ch into ch, clears stage to 0, moves to CALC.
REQ-017 IDLE: din_ch>=CH is dropped, no state change, delay lines untouched.
REQ-018 CALC, each cen edge: acc <= acc - mem[ch][stage][M-1]; mem[ch][stage] shifts with pre-subtraction acc entering slot 0; stage increments.
REQ-019 CALC ends after stage N-1: dout <= result, dout_ch <= ch, go to DONE.
REQ-020 DONE persists one cen cycle, then returns to IDLE; dout_valid is held while cen=0.
REQ-021 Latency: sample accepted on cen edge k sets dout_valid at edge k+N and clears it at edge k+N+1; throughput is one sample per N+2 cen cycles.
REQ-022 din_valid during CALC/DONE is ignored; upstream holds it until din_ready=1.
REQ-023 Arithmetic is two's complement modulo 2^W (wrap, no saturation), as required for CIC operation.
REQ-024 Each channel owns its N x M history words; channels never interact.
REQ-025 With N=1, M=1, CH=1 the output sequence equals y[n] = x[n] - x[n-1].

Reset
REQ-026 rst=1 asynchronously forces IDLE, all mem to 0, acc, stage and ch to 0, dout to 0, dout_ch to 0, dout_valid to 0.
REQ-027 rst asserted mid-CALC discards the in-flight sample; its partial history updates are also cleared.

Configuration
REQ-028 With macro JT12_COMB_MCH_BYPASS_EN defined, input port byp (1 bit) is present; byp=1 at acceptance forces dout = din with identical latency; delay lines still update.
REQ-029 Without JT12_COMB_MCH_BYPASS_EN, port byp is absent and every sample is filtered.

Structure
REQ-030 Package jt12_comb_pkg holds the state enum, the CHW width function, and parameter limit constants (M_MAX=4, N_MAX=5, CH_MAX=8).
REQ-031 Sub-module jt12_comb_dly holds the CH x N x M history storage with read-tap/shift-write port addressed by (ch, stage); the top module holds the FSM, acc and subtractor.

Verification
REQ-032 Async rst pulse mid-CALC with no clk edge -> dout_valid=0 immediately; next sample x=7 yields dout=7 (zero history).
REQ-033 W=16, M=1, N=1, CH=1; inputs 100, 250, 250, -32768 -> dout 100, 150, 0, 32518 (wrap).
REQ-034 N=2, M=2, CH=1; impulse 1000 then zeros -> dout 1000, 0, -2000, 0, 1000, 0, 0.
REQ-035 CH=2 interleaved; ch0 constant 5, ch1 ramp 0, 10, 20 -> ch0 5, 0, 0; ch1 0, 10, 10; dout_ch matches each; no crosstalk.
REQ-036 N=3, cen every 2nd clk -> dout_valid exactly 3 cen edges after accept; din_ready low 4 cen cycles; held din_valid accepted on return to IDLE; din_ch=CH dropped.
REQ-037 With JT12_COMB_MCH_BYPASS_EN, byp=1 on 100 then byp=0 on 250 -> dout 100 then 150.
